// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer: opcodes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Counter must hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side handshake and HI/LO bus of the multiply/divide sequencer.
// master = issuing pipeline, slave = muldiv_ctrl.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
// For divide the LSB of part_o is left 0; the caller inserts qbit_o.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] part_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] part_o,
    output logic               qbit_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        part_o  = '0;
        qbit_o  = 1'b0;
        sum     = {1'b0, part_i[2*WIDTH-1:WIDTH]}
                + {1'b0, (part_i[0] ? opnd_i : {WIDTH{1'b0}})};
        shifted = part_i[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, opnd_i};
        if (is_div_i) begin
            // Remainder stays below the divisor, so trial[WIDTH] is a clean borrow flag.
            qbit_o = ~trial[WIDTH];
            part_o = {(qbit_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0]),
                      part_i[WIDTH-2:0], 1'b0};
        end else begin
            part_o = {sum, part_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO and start/busy/done handshake.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] part_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;

    op_e                op_d;
    logic               is_div_d;
    logic               signed_d;
    logic               a_neg_d;
    logic               b_neg_d;
    logic [WIDTH-1:0]   a_mag_d;
    logic [WIDTH-1:0]   b_mag_d;
    logic [2*WIDTH-1:0] step_part;
    logic               step_qbit;
    logic [2*WIDTH-1:0] part_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .part_i   (part_q),
        .opnd_i   (opnd_q),
        .part_o   (step_part),
        .qbit_o   (step_qbit)
    );

    always_comb begin
        op_d     = op_e'(bus.op);
        is_div_d = (op_d == OP_DIVU) || (op_d == OP_DIV);
        signed_d = 1'b0;
`ifdef MULDIV_SIGNED_EN
        signed_d = (op_d == OP_MULT) || (op_d == OP_DIV);
`endif
        a_neg_d  = signed_d & bus.a[WIDTH-1];
        b_neg_d  = signed_d & bus.b[WIDTH-1];
        a_mag_d  = a_neg_d ? -bus.a : bus.a;
        b_mag_d  = b_neg_d ? -bus.b : bus.b;
        part_d   = {step_part[2*WIDTH-1:1], is_div_q ? step_qbit : step_part[0]};
        prod_d   = neg_res_q ? -part_q : part_q;
        quot_d   = neg_res_q ? -part_q[WIDTH-1:0] : part_q[WIDTH-1:0];
        rem_d    = neg_rem_q ? -part_q[2*WIDTH-1:WIDTH] : part_q[2*WIDTH-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            part_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        is_div_q   <= is_div_d;
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        if (is_div_d && (bus.b == '0)) begin
                            // Divide-by-zero bypasses RUN; FIX copies part_q straight out.
                            part_q    <= {bus.a, {WIDTH{1'b1}}};
                            dz_q      <= 1'b1;
                            neg_res_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= S_FIX;
                        end else begin
                            part_q    <= {{WIDTH{1'b0}}, (is_div_d ? a_mag_d : b_mag_d)};
                            opnd_q    <= is_div_d ? b_mag_d : a_mag_d;
                            dz_q      <= 1'b0;
                            neg_res_q <= a_neg_d ^ b_neg_d;
                            neg_rem_q <= is_div_d & a_neg_d;
                            state_q   <= S_RUN;
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wdata;
                        if (bus.lo_we) lo_q <= bus.wdata;
                    end
                end
                S_RUN: begin
                    part_q <= part_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (dz_q) begin
                        hi_q       <= part_q[2*WIDTH-1:WIDTH];
                        lo_q       <= part_q[WIDTH-1:0];
                        div_zero_q <= 1'b1;
                    end else if (is_div_q) begin
                        hi_q <= rem_d;
                        lo_q <= quot_d;
                    end else begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
